mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath, servicing MULT, MULTU, DIV, DIVU, MTHI and MTLO and holding the architectural HI/LO registers. Where the bitwise logic ops consume two operands combinationally in a single cycle, this block accepts operands through a start/busy/done handshake and produces its results over many cycles. It sits beside the ALU in the execute stage. The pipeline stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mips_pkg.sv | 19 +
 rtl/cond_negate.sv | 12 +
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, divide-by-zero quotient.
package mips_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'b00,
        MD_CALC  = 2'b01,
        MD_FIXUP = 2'b10
    } md_state_t;

    localparam logic [31:0] MD_DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's complement: result = neg ? -value : value. Combinational, no backpressure.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] result
);

    assign result = neg ? (~value + 1'b1) : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; WIDTH+1 edges per op, start ignored while busy.
// Optional MULT_DIV_EARLY_OUT_EN: zero-operand ops skip the iterations and finish 2 edges after start.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             write_hi,
    input  logic             write_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          state, state_next;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic               is_div_q, neg_q, neg_r, div0_q, early_q;
    logic               load, step, finish, hold;

    // Operand decode at the start-sampling edge
    logic             is_signed, is_div, div0_in, neg_a, neg_b, early_in;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign div0_in   = is_div && (input_b == '0);
    // Divide by zero keeps the raw dividend so HI reproduces it unmodified
    assign neg_a     = is_signed && input_a[WIDTH-1] && !div0_in;
    assign neg_b     = is_signed && input_b[WIDTH-1];

`ifdef MULT_DIV_EARLY_OUT_EN
    assign early_in = is_div ? ((input_a == '0) && (input_b != '0))
                             : ((input_a == '0) || (input_b == '0));
`else
    assign early_in = 1'b0;
`endif

    cond_negate #(.WIDTH(WIDTH)) u_abs_a (.neg(neg_a), .value(input_a), .result(abs_a));
    cond_negate #(.WIDTH(WIDTH)) u_abs_b (.neg(neg_b), .value(input_b), .result(abs_b));

    // One iteration: acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH:0] mult_sum, rem_sh, diff;

    always_comb begin
        mult_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
        rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff     = rem_sh - {1'b0, mag_b};
        if (!is_div_q)
            acc_step = {mult_sum, acc[WIDTH-1:1]};
        else if (!diff[WIDTH])
            acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Sign fixup of the finished result
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

    cond_negate #(.WIDTH(2*WIDTH)) u_fix_prod (.neg(neg_q), .value(acc), .result(prod_fix));
    cond_negate #(.WIDTH(WIDTH)) u_fix_quot (.neg(neg_q), .value(acc[WIDTH-1:0]), .result(quot_fix));
    cond_negate #(.WIDTH(WIDTH)) u_fix_rem (.neg(neg_r), .value(acc[2*WIDTH-1:WIDTH]), .result(rem_fix));

    always_comb begin
        res_hi = rem_fix;
        res_lo = quot_fix;
        if (!is_div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            res_hi = mag_a;
            res_lo = WIDTH'($signed(MD_DIV0_LO));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != MD_IDLE);
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        hold       = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = early_in ? MD_FIXUP : MD_CALC;
                end
            end
            MD_CALC: begin
                step = 1'b1;
                if (cnt == CW'(WIDTH - 1)) state_next = MD_FIXUP;
            end
            MD_FIXUP: begin
                // Early-out spends one extra cycle here so done lands 2 edges after start
                if (early_q) begin
                    hold = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = MD_IDLE;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0_q   <= 1'b0;
            early_q  <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                cnt      <= '0;
                mag_a    <= abs_a;
                mag_b    <= abs_b;
                acc      <= early_in ? '0 : {{WIDTH{1'b0}}, abs_a};
                is_div_q <= is_div;
                neg_q    <= is_signed && !div0_in && !early_in && (input_a[WIDTH-1] ^ input_b[WIDTH-1]);
                neg_r    <= is_signed && !div0_in && !early_in && input_a[WIDTH-1];
                div0_q   <= div0_in;
                early_q  <= early_in;
            end
            if (step) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
            if (hold) early_q <= 1'b0;
            if (finish) begin
                hi   <= res_hi;
                lo   <= res_lo;
                done <= 1'b1;
            end
            if ((state == MD_IDLE) && !start && write_hi) hi <= input_a;
            if ((state == MD_IDLE) && !start && write_lo) lo <= input_a;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit: latency, results, HI/LO writes, reset abort, protocol.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] input_a = '0;
    logic [31:0] input_b = '0;
    logic        write_hi = 1'b0;
    logic        write_lo = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

`ifdef MULT_DIV_EARLY_OUT_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 33;
`endif

    mult_div_unit #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .input_a(input_a), .input_b(input_b),
        .write_hi(write_hi), .write_lo(write_lo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call right after a negedge; the next posedge (E0) samples start.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic wh);
        op = o; input_a = a; input_b = b; start = 1'b1; write_hi = wh;
        @(negedge clock);
        start = 1'b0; write_hi = 1'b0;
    endtask

    // Returns edges after E0 at which done was seen (-1 on timeout); optionally pokes
    // start and write_hi while busy at iteration inj.
    task automatic wait_done(input int inj, output int edges);
        edges = -1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (n == inj) begin
                start = 1'b1; op = OP_DIVU; input_a = 32'h1234; input_b = 32'd3; write_hi = 1'b1;
            end else if (n == inj + 1) begin
                start = 1'b0; write_hi = 1'b0;
            end
            if (done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int lat,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int e;
        launch(o, a, b, 1'b0);
        wait_done(0, e);
        check({tag, "_lat"}, e, lat);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int e;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // MTLO in idle
        input_a = 32'hABCD; write_lo = 1'b1;
        @(negedge clock);
        write_lo = 1'b0;
        check("mtlo", lo, 32'hABCD);
        check("mtlo_hi_untouched", hi, 0);

        // Reset during iteration 10 aborts with no done
        launch(OP_MULT, 32'd3, 32'd5, 1'b0);
        check("busy_after_e0", busy, 1);
        repeat (9) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_lo", lo, 0);
        check("abort_hi", hi, 0);
        @(negedge clock);
        reset = 1'b0;
        wait_done(0, e);
        check("abort_no_done", e, -1);

        run("mult", OP_MULT, 32'hFFFF_FFFF, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        check("mult_busy_at_done", busy, 0);
        run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h2, 33, 32'h1, 32'hFFFF_FFFE);
        run("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Back-to-back: start issued in the done cycle
        launch(OP_DIVU, 32'd100, 32'd7, 1'b0);
        wait_done(0, e);
        check("b2b_lat", e, 33);
        check("b2b_hi", hi, 32'h2);
        check("b2b_lo", lo, 32'hE);

        @(negedge clock);
        run("divu0", OP_DIVU, 32'd5, 32'd0, 33, 32'h5, 32'hFFFF_FFFF);
        run("div0_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 33, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        run("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);

        // start and MTHI while busy are both ignored
        launch(OP_MULTU, 32'd6, 32'd7, 1'b0);
        wait_done(5, e);
        check("busy_start_lat", e, 33);
        check("busy_start_hi", hi, 0);
        check("busy_start_lo", lo, 32'd42);
        repeat (3) @(negedge clock);
        check("no_queued_op", busy, 0);
        check("mthi_busy_ignored", hi, 0);

        // start beats a coincident MTHI
        launch(OP_MULTU, 32'h10, 32'h10, 1'b1);
        check("start_wins_hi", hi, 0);
        wait_done(0, e);
        check("start_wins_lo", lo, 32'h100);

        // Zero-operand cases; latency depends on the early-out build
        @(negedge clock);
        run("mult_zero", OP_MULT, 32'hFFFF_FFFB, 32'd0, ZERO_LAT, 32'h0, 32'h0);
        run("mult_nz", OP_MULT, 32'd7, 32'd9, 33, 32'h0, 32'd63);
        run("div_zero_num", OP_DIV, 32'd0, 32'hFFFF_FFFB, ZERO_LAT, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
